shot_sequencer: RTL
===================

Name: shot_sequencer

Overview:
Sequences the light-gun shot protocol between the trigger/photodiode inputs and the pattern generator. An accepted trigger pull forces one or more all-black frames, then one or more target-only frames. It measures photodiode response in each phase and issues a single hit or miss verdict. It sits between the PLL-clocked VGA timing block and the pattern generator: it consumes the frame-start pulse and drives the pattern generator's video mode select.

Parameters:
SYNC_STAGES, 2, flip-flop stages on trigger and detect.
DEBOUNCE_CYCLES, 250000, trigger must be stable this many clk cycles (~10 ms at 25 MHz).
BLACK_FRAMES, 1, number of black frames per shot.
TARGET_FRAMES, 1, number of target frames per shot.
DETECT_MIN, 64, minimum detect-high cycles in a phase to count as "light seen".
COOLDOWN_FRAMES, 15, frames after a verdict before the next trigger is accepted.
SHOTS, 3, shots loaded per round.

Ports:
clk  in  1  pixel clock from PLL
reset  in  1  asynchronous, active-low reset
trigger  in  1  raw gun trigger, active-high, asynchronous
detect  in  1  raw photodiode, active-high, asynchronous
frame_start  in  1  one-cycle pulse at row 0, col 0 from VGA timing
round_start  in  1  one-cycle pulse; reloads shots_left
video_mode  out  2  0=NORMAL, 1=BLACK, 2=TARGET (3 unused)
busy  out  1  high in any state other than IDLE
hit  out  1  one-cycle verdict pulse
miss  out  1  one-cycle verdict pulse
shots_left  out  2  remaining shots, ceil(log2(SHOTS+1)) wide
hit_count  out  8  saturating hit total since reset

Behaviour:
- Reset (async assert, sync-deassert assumed upstream): state IDLE, video_mode NORMAL, busy/hit/miss 0, shots_left=SHOTS, hit_count 0, counters 0, debounce state "released".
- trigger path: SYNC_STAGES synchronizer -> debouncer -> rising-edge pulse trig_p (one cycle). Total latency from a stable raw edge = SYNC_STAGES + DEBOUNCE_CYCLES cycles, +/-1.
- detect path: SYNC_STAGES synchronizer only. No debounce.
- States: IDLE, ARM, BLACK, TARGET, RESULT, COOLDOWN.
- IDLE: on trig_p with shots_left>0 -> ARM, decrement shots_left. trig_p with shots_left==0 is ignored.
- ARM: video_mode NORMAL. On frame_start -> BLACK, clear frame counter and detect counter.
- BLACK: video_mode BLACK. Count detect-high cycles, saturating at DETECT_MIN. Each frame_start increments the frame counter. When the frame counter reaches BLACK_FRAMES at a frame_start: latch cheat = (count>=DETECT_MIN), clear both counters, go to TARGET.
- TARGET: video_mode TARGET. Count detect the same way. At the TARGET_FRAMES-th frame_start, latch seen = (count>=DETECT_MIN) and go to RESULT.
- RESULT: lasts one cycle. video_mode NORMAL. hit=seen&&!cheat, otherwise miss=1. On hit, hit_count increments, saturating at 255. Then go to COOLDOWN.
- COOLDOWN: video_mode NORMAL. Decrement on each frame_start from COOLDOWN_FRAMES. At 0, go to IDLE. trig_p is ignored here.
- video_mode is registered. It changes on the cycle after the frame_start that causes the transition, so row 0 col 0 pixel latency is 1 cycle. The pattern generator tolerates this.
- A detect sample taken in the same cycle as the frame_start that ends a phase counts toward the ending phase.
- trig_p outside IDLE is dropped, not queued.
- round_start reloads shots_left=SHOTS in any state. If round_start coincides with the IDLE decrement, the reload wins. round_start does not abort a shot in progress.
- hit and miss are never both high; each lasts exactly one cycle per shot.
- Reset asserted mid-shot: immediate return to IDLE/NORMAL. No verdict is issued.

Decomposition:
- Package duck_pkg holds:
  - enum video_mode_t {VM_NORMAL, VM_BLACK, VM_TARGET}
  - enum shot_state_t
  - width localparams for counters
- Sub-module trigger_debounce (synchronizer, stability counter, rising-edge pulse output) is instantiated once for trigger. The detect synchronizer is inline.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=8, DETECT_MIN=4, COOLDOWN_FRAMES=2, SHOTS=3, frame_start every 100 cycles.
- Clean hit: trigger held 20 cycles, detect low in BLACK, high 10 cycles in TARGET -> mode sequence NORMAL, BLACK, TARGET, NORMAL; one hit pulse; hit_count=1; shots_left=2.
- Cheat: detect held high throughout -> miss pulse, no hit, hit_count unchanged.
- Weak light: detect high only 3 cycles in TARGET -> miss.
- Bounce and lockout:
  - trigger toggling every 3 cycles produces no shot.
  - a trigger during COOLDOWN is ignored.
  - busy drops exactly 2 frame_starts after RESULT.
- Ammo: 3 shots, then a 4th trigger -> no ARM, shots_left=0. round_start -> shots_left=3. round_start together with trig_p in IDLE -> shots_left=3.
- Reset asserted during TARGET -> video_mode NORMAL and busy 0 asynchronously; no hit/miss pulse after release.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared types and width helpers for the light-gun shot sequencer.
package duck_pkg;

  typedef enum logic [1:0] {
    VM_NORMAL = 2'd0,
    VM_BLACK  = 2'd1,
    VM_TARGET = 2'd2
  } video_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_BLACK,
    ST_TARGET,
    ST_RESULT,
    ST_COOLDOWN
  } shot_state_t;

  localparam int HIT_W = 8;

  // Bits needed to hold the value n (never less than one).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shot_sequencer_if.sv
// Frame/round control in, video mode and shot status out.
interface shot_sequencer_if import duck_pkg::*; #(
  parameter int SHOTS = 3
);
  localparam int SL_W = cnt_w(SHOTS);

  logic              frame_start;
  logic              round_start;
  video_mode_t       video_mode;
  logic              busy;
  logic              hit;
  logic              miss;
  logic [SL_W-1:0]   shots_left;
  logic [HIT_W-1:0]  hit_count;

  modport master (
    output frame_start, round_start,
    input  video_mode, busy, hit, miss, shots_left, hit_count
  );

  modport slave (
    input  frame_start, round_start,
    output video_mode, busy, hit, miss, shots_left, hit_count
  );

endinterface

// File: rtl/trigger_debounce.sv
// Synchronizes the raw trigger, requires it stable for DEBOUNCE_CYCLES, and
// emits a one-cycle pulse on each debounced press.
module trigger_debounce import duck_pkg::*; #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          stab_cnt;
  logic                   level;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Down-counter restarts whenever the input agrees with the accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stab_cnt <= '0;
      level    <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      pulse  <= 1'b0;
      if (synced == level) begin
        stab_cnt <= RELOAD;
      end else if (stab_cnt == '0) begin
        level    <= synced;
        pulse    <= synced;
        stab_cnt <= RELOAD;
      end else begin
        stab_cnt <= stab_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/shot_sequencer.sv
// Light-gun shot protocol: black frame(s), target frame(s), then one verdict.
//   state    | meaning
//   IDLE     | waiting for an accepted trigger press
//   ARM      | shot accepted, waiting for next frame start
//   BLACK    | screen black, counting photodiode light (cheat check)
//   TARGET   | target shown, counting photodiode light
//   RESULT   | one cycle, hit or miss pulse
//   COOLDOWN | frame lockout before next trigger is accepted
module shot_sequencer import duck_pkg::*; #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int DETECT_MIN      = 64,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int SHOTS           = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              detect,
  shot_sequencer_if.slave   bus
);

  localparam int FRM_W = cnt_w((BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES);
  localparam int DET_W = cnt_w(DETECT_MIN);
  localparam int CD_W  = cnt_w(COOLDOWN_FRAMES);
  localparam int SL_W  = cnt_w(SHOTS);

  localparam logic [FRM_W-1:0] BLACK_LAST  = FRM_W'(BLACK_FRAMES - 1);
  localparam logic [FRM_W-1:0] TARGET_LAST = FRM_W'(TARGET_FRAMES - 1);
  localparam logic [DET_W-1:0] DET_MIN_V   = DET_W'(DETECT_MIN);
  localparam logic [CD_W-1:0]  CD_INIT     = CD_W'(COOLDOWN_FRAMES);
  localparam logic [SL_W-1:0]  SHOTS_V     = SL_W'(SHOTS);
  localparam logic [HIT_W-1:0] HIT_MAX     = '1;

  shot_state_t        state_q, state_d;
  video_mode_t        mode_q, mode_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic [DET_W-1:0]   det_cnt_q, det_cnt_d, det_sat;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               cheat_q, cheat_d;
  logic               seen_q, seen_d;
  logic [SL_W-1:0]    shots_q;
  logic [HIT_W-1:0]   hits_q;
  logic [SYNC_STAGES-1:0] det_sync;
  logic               det_s;
  logic               light;
  logic               trig_p;
  logic               verdict_hit;

  trigger_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_trig_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (trigger),
    .pulse (trig_p)
  );

  assign det_s = det_sync[SYNC_STAGES-1];

  // Includes this cycle's sample so a phase-ending frame_start still counts it.
  assign det_sat = (det_cnt_q >= DET_MIN_V) ? DET_MIN_V : det_cnt_q + DET_W'(det_s);
  assign light   = (det_sat >= DET_MIN_V);

  always_comb begin
    state_d   = state_q;
    frm_d     = frm_q;
    det_cnt_d = det_cnt_q;
    cd_d      = cd_q;
    cheat_d   = cheat_q;
    seen_d    = seen_q;
    mode_d    = VM_NORMAL;
    case (state_q)
      ST_IDLE: begin
        if (trig_p && shots_q != '0) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.frame_start) begin
          state_d   = ST_BLACK;
          frm_d     = BLACK_LAST;
          det_cnt_d = '0;
        end
      end
      ST_BLACK: begin
        det_cnt_d = det_sat;
        if (bus.frame_start) begin
          if (frm_q == '0) begin
            cheat_d   = light;
            frm_d     = TARGET_LAST;
            det_cnt_d = '0;
            state_d   = ST_TARGET;
          end else begin
            frm_d = frm_q - FRM_W'(1);
          end
        end
      end
      ST_TARGET: begin
        det_cnt_d = det_sat;
        if (bus.frame_start) begin
          if (frm_q == '0) begin
            seen_d  = light;
            state_d = ST_RESULT;
          end else begin
            frm_d = frm_q - FRM_W'(1);
          end
        end
      end
      ST_RESULT: begin
        cd_d    = CD_INIT;
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_q == '0) begin
          state_d = ST_IDLE;
        end else if (bus.frame_start) begin
          cd_d = cd_q - CD_W'(1);
          if (cd_q == CD_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_BLACK:  mode_d = VM_BLACK;
      ST_TARGET: mode_d = VM_TARGET;
      default:   mode_d = VM_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= VM_NORMAL;
      frm_q     <= '0;
      det_cnt_q <= '0;
      cd_q      <= '0;
      cheat_q   <= 1'b0;
      seen_q    <= 1'b0;
      det_sync  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      frm_q     <= frm_d;
      det_cnt_q <= det_cnt_d;
      cd_q      <= cd_d;
      cheat_q   <= cheat_d;
      seen_q    <= seen_d;
      det_sync  <= {det_sync[SYNC_STAGES-2:0], detect};
    end
  end

  assign verdict_hit = seen_q && !cheat_q;

  // A round reload takes priority over the decrement of an accepted shot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shots_q <= SHOTS_V;
      hits_q  <= '0;
    end else begin
      if (bus.round_start) begin
        shots_q <= SHOTS_V;
      end else if (state_q == ST_IDLE && trig_p && shots_q != '0) begin
        shots_q <= shots_q - SL_W'(1);
      end
      if (state_q == ST_RESULT && verdict_hit && hits_q != HIT_MAX) begin
        hits_q <= hits_q + HIT_W'(1);
      end
    end
  end

  assign bus.video_mode = mode_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.hit        = (state_q == ST_RESULT) && verdict_hit;
  assign bus.miss       = (state_q == ST_RESULT) && !verdict_hit;
  assign bus.shots_left = shots_q;
  assign bus.hit_count  = hits_q;

endmodule
